// File: rtl/hdmi_sched_pkg.sv
// Shared encodings and period lengths for the HDMI period scheduler.
package hdmi_sched_pkg;

    localparam int unsigned PRE_LEN      = 8;
    localparam int unsigned GB_LEN       = 2;
    localparam int unsigned PKT_LEN      = 32;
    localparam int unsigned CTRL_CNT_MAX = 63;

    localparam logic [2:0] MODE_CTRL  = 3'd0;
    localparam logic [2:0] MODE_VIDEO = 3'd1;
    localparam logic [2:0] MODE_VGB   = 3'd2;
    localparam logic [2:0] MODE_DATA  = 3'd3;
    localparam logic [2:0] MODE_DGB   = 3'd4;

    localparam logic [3:0] CTL_NONE = 4'b0000;
    localparam logic [3:0] CTL_VPRE = 4'b0001;
    localparam logic [3:0] CTL_DPRE = 4'b0101;

    typedef enum logic [2:0] {
        ST_CTRL,
        ST_VPRE,
        ST_VGB,
        ST_VIDEO,
        ST_DPRE,
        ST_DGB_LEAD,
        ST_DATA,
        ST_DGB_TRAIL
    } state_t;

    // Registered channel-control payload presented to the TMDS encoders.
    typedef struct packed {
        logic [2:0] mode;
        logic [3:0] ctl;
        logic       take;
        logic [4:0] idx;
    } sched_out_t;

endpackage

// File: rtl/hdmi_period_scheduler.sv
// Schedules HDMI control, video-preamble and data-island periods on the pixel clock.
// Define HDMI_SCHED_MULTI_PACKET_EN to allow back-to-back packets within one data island.
module hdmi_period_scheduler
    import hdmi_sched_pkg::*;
#(
    parameter int unsigned MAX_PACKETS = 18,
    parameter int unsigned MIN_CTRL    = 12
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        de_in,
    input  logic [11:0] blank_left,
    input  logic        packet_pending,
    output logic [2:0]  mode,
    output logic [3:0]  ctl,
    output logic        packet_take,
    output logic [4:0]  packet_idx,
    output logic        sched_err
);

`ifdef HDMI_SCHED_MULTI_PACKET_EN
    localparam bit MULTI_EN = 1'b1;
`else
    localparam bit MULTI_EN = 1'b0;
`endif

    // Preamble must start exactly preamble+guard cycles ahead of the first active pixel.
    localparam logic [11:0] VPRE_AT      = 12'(PRE_LEN + GB_LEN);
    localparam logic [11:0] ISLAND_ROOM  = 12'(44 + MIN_CTRL + 10);
    localparam logic [11:0] PACKET_ROOM  = 12'(34 + MIN_CTRL + 10);
    localparam logic [5:0]  MIN_CTRL_CNT = 6'(MIN_CTRL);

    state_t     state_q, state_d;
    logic [4:0] ph_q, ph_d;
    logic [5:0] ctrl_q, ctrl_d;
    logic [4:0] sent_q, sent_d;
    logic       err_q, err_d;
    sched_out_t out_q, out_d;
    logic       island_ok_c;
    logic       more_ok_c;

    assign island_ok_c = packet_pending && (ctrl_q >= MIN_CTRL_CNT) && (blank_left >= ISLAND_ROOM);
    assign more_ok_c   = MULTI_EN && packet_pending && (32'(sent_q) < MAX_PACKETS)
                         && (blank_left >= PACKET_ROOM);

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q <= ST_CTRL;
            ph_q    <= '0;
            ctrl_q  <= '0;
            sent_q  <= '0;
            err_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            ctrl_q  <= ctrl_d;
            sent_q  <= sent_d;
            err_q   <= err_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q + 5'd1;
        ctrl_d     = '0;
        sent_d     = sent_q;
        err_d      = err_q;
        out_d      = '0;
        out_d.ctl  = CTL_NONE;

        unique case (state_q)
            ST_CTRL: begin
                ctrl_d = (ctrl_q == 6'(CTRL_CNT_MAX)) ? ctrl_q : ctrl_q + 6'd1;
                if (blank_left == VPRE_AT) begin
                    state_d = ST_VPRE;
                    ph_d    = '0;
                    ctrl_d  = '0;
                end else if (island_ok_c) begin
                    state_d = ST_DPRE;
                    ph_d    = '0;
                    ctrl_d  = '0;
                    sent_d  = '0;
                end
            end
            ST_VPRE: begin
                if (ph_q == 5'(PRE_LEN - 1)) begin
                    state_d = ST_VGB;
                    ph_d    = '0;
                end
            end
            ST_VGB: begin
                if (ph_q == 5'(GB_LEN - 1)) state_d = ST_VIDEO;
            end
            ST_VIDEO: begin
                if (!de_in) state_d = ST_CTRL;
            end
            ST_DPRE: begin
                if (ph_q == 5'(PRE_LEN - 1)) begin
                    state_d = ST_DGB_LEAD;
                    ph_d    = '0;
                end
            end
            ST_DGB_LEAD: begin
                if (ph_q == 5'(GB_LEN - 1)) begin
                    state_d    = ST_DATA;
                    ph_d       = '0;
                    out_d.take = 1'b1;
                    sent_d     = sent_q + 5'd1;
                end
            end
            ST_DATA: begin
                if (ph_q == 5'(PKT_LEN - 1)) begin
                    ph_d = '0;
                    if (more_ok_c) begin
                        out_d.take = 1'b1;
                        sent_d     = sent_q + 5'd1;
                    end else begin
                        state_d = ST_DGB_TRAIL;
                    end
                end
            end
            ST_DGB_TRAIL: begin
                if (ph_q == 5'(GB_LEN - 1)) state_d = ST_CTRL;
            end
        endcase

        // Active video arriving outside the video path aborts whatever period is running.
        if (de_in && (state_q != ST_VGB) && (state_q != ST_VIDEO)) begin
            state_d    = ST_VIDEO;
            err_d      = 1'b1;
            out_d.take = 1'b0;
            sent_d     = sent_q;
            ctrl_d     = '0;
        end

        unique case (state_d)
            ST_CTRL:      out_d.mode = MODE_CTRL;
            ST_VPRE:      begin out_d.mode = MODE_CTRL; out_d.ctl = CTL_VPRE; end
            ST_VGB:       out_d.mode = MODE_VGB;
            ST_VIDEO:     out_d.mode = MODE_VIDEO;
            ST_DPRE:      begin out_d.mode = MODE_CTRL; out_d.ctl = CTL_DPRE; end
            ST_DGB_LEAD:  out_d.mode = MODE_DGB;
            ST_DATA:      begin out_d.mode = MODE_DATA; out_d.idx = ph_d; end
            ST_DGB_TRAIL: out_d.mode = MODE_DGB;
        endcase
    end

    assign mode        = out_q.mode;
    assign ctl         = out_q.ctl;
    assign packet_take = out_q.take;
    assign packet_idx  = out_q.idx;
    assign sched_err   = err_q;

endmodule
